// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the intersection scheduler: light codes, FSM states,
// phase indices and the round-robin picker.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    MT_G   = 3'd2,
    MT_Y   = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    PED    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_MT   = 2'd0,
    PH_SIDE = 2'd1,
    PH_PED  = 2'd2
  } phase_t;

  // Nearest pending phase after ptr in MT->SIDE->PED->MT order; the loop runs
  // farthest-first so the nearest candidate is the last one written.
  function automatic phase_t rr_pick(input logic [2:0] pend, input phase_t ptr);
    phase_t     win;
    logic [1:0] idx;
    win = ptr;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (pend[idx]) win = phase_t'(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request/light bundle between the scheduler and its environment.
interface traffic_phase_scheduler_if;
    logic       tick;
    logic       req_mt;
    logic       req_side;
    logic       req_ped;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic       walk;
    logic [2:0] grant;

    modport master (
        output tick, req_mt, req_side, req_ped,
        input  light_M1, light_M2, light_MT, light_S, walk, grant
    );

    modport slave (
        input  tick, req_mt, req_side, req_ped,
        output light_M1, light_M2, light_MT, light_S, walk, grant
    );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Down counter for phase durations: load wins, otherwise decrements on tick
// until it reaches zero and then holds there.
module phase_timer #(
    parameter int             TW      = 4,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_tick,
    output logic          o_zero
);
    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_tick && (r_cnt != '0))
            r_cnt <= r_cnt - TW'(1);
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach intersection sequencer: main road rests green, latched
// turn/side/pedestrian requests are served round-robin with yellow clearance.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int T_MAIN_MIN = 6,
    parameter int T_YEL      = 2,
    parameter int T_MT       = 3,
    parameter int T_SIDE     = 4,
    parameter int T_PED      = 5,
    parameter int TW         = 4
) (
    input logic                       clk,
    input logic                       rst,
    traffic_phase_scheduler_if.slave  bus
);
    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_pend;
    phase_t        r_rr_ptr;
    phase_t        r_target;
    logic [2:0]    r_grant;
    phase_t        w_win;
    logic          w_zero;
    logic          w_go;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic [2:0]    w_enter;
    logic [2:0]    w_clr;
    logic [2:0]    w_m1, w_m2, w_mt, w_s;
    logic          w_walk;

    phase_timer #(
        .TW      (TW),
        .RST_VAL (TW'(T_MAIN_MIN - 1))
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (bus.tick),
        .o_zero     (w_zero)
    );

    assign w_win = rr_pick(r_pend, r_rr_ptr);
    assign w_go  = bus.tick && w_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= MAIN_G;
        else
            r_state <= w_next_state;
    end

    // Next state, timer reload and the green-entry pulses that clear requests.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_enter      = 3'b000;
        unique case (r_state)
            MAIN_G: if (w_go && (r_pend != 3'b000)) begin
                w_next_state = MAIN_Y;
                w_load       = 1'b1;
                w_load_val   = TW'(T_YEL - 1);
            end
            MAIN_Y: if (w_go) begin
                w_load = 1'b1;
                unique case (r_target)
                    PH_MT: begin
                        w_next_state = MT_G;
                        w_load_val   = TW'(T_MT - 1);
                        w_enter      = 3'b001;
                    end
                    PH_SIDE: begin
                        w_next_state = SIDE_G;
                        w_load_val   = TW'(T_SIDE - 1);
                        w_enter      = 3'b010;
                    end
                    default: begin
                        w_next_state = PED;
                        w_load_val   = TW'(T_PED - 1);
                        w_enter      = 3'b100;
                    end
                endcase
            end
            MT_G, SIDE_G: if (w_go) begin
                w_next_state = (r_state == MT_G) ? MT_Y : SIDE_Y;
                w_load       = 1'b1;
                w_load_val   = TW'(T_YEL - 1);
            end
            MT_Y, SIDE_Y, PED: if (w_go) begin
                w_next_state = MAIN_G;
                w_load       = 1'b1;
                w_load_val   = TW'(T_MAIN_MIN - 1);
            end
            default: begin
                w_next_state = MAIN_G;
                w_load       = 1'b1;
                w_load_val   = TW'(T_MAIN_MIN - 1);
            end
        endcase
    end

    // A request arriving while its own phase is green is dropped, as is one
    // arriving on the very edge that enters that green.
    always_comb begin
        w_clr = w_enter;
        if (r_state == MT_G)   w_clr[PH_MT]   = 1'b1;
        if (r_state == SIDE_G) w_clr[PH_SIDE] = 1'b1;
        if (r_state == PED)    w_clr[PH_PED]  = 1'b1;
    end

    // rr_ptr resets to PED so that the first search after reset starts at MT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend   <= 3'b000;
            r_rr_ptr <= PH_PED;
            r_target <= PH_MT;
            r_grant  <= 3'b000;
        end else begin
            r_pend  <= (r_pend | {bus.req_ped, bus.req_side, bus.req_mt}) & ~w_clr;
            r_grant <= w_enter;
            if ((r_state == MAIN_G) && (w_next_state == MAIN_Y)) begin
                r_target <= w_win;
                r_rr_ptr <= w_win;
            end
        end
    end

    always_comb begin
        w_m1   = LT_RED;
        w_m2   = LT_RED;
        w_mt   = LT_RED;
        w_s    = LT_RED;
        w_walk = 1'b0;
        unique case (r_state)
            MAIN_G: begin
                w_m1 = LT_GRN;
                w_m2 = LT_GRN;
            end
            MAIN_Y: begin
                w_m1 = (r_target == PH_MT) ? LT_GRN : LT_YEL;
                w_m2 = LT_YEL;
            end
            MT_G: begin
                w_m1 = LT_GRN;
                w_mt = LT_GRN;
            end
            MT_Y: begin
                w_m1 = LT_YEL;
                w_mt = LT_YEL;
            end
            SIDE_G: w_s    = LT_GRN;
            SIDE_Y: w_s    = LT_YEL;
            PED:    w_walk = 1'b1;
            default: ;
        endcase
    end

    assign bus.light_M1 = w_m1;
    assign bus.light_M2 = w_m2;
    assign bus.light_MT = w_mt;
    assign bus.light_S  = w_s;
    assign bus.walk     = w_walk;
    assign bus.grant    = r_grant;
endmodule
